// File: rtl/instruction_fetch_unit.sv
// Instruction fetch stage: owns the PC, runs the busywait handshake to instruction
// memory and loads the IF/ID register, honouring stalls and EX-stage redirects.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic [31:0] imem_addr_o,
  output logic        imem_read_o,
  input  logic [31:0] imem_readdata_i,
  input  logic        imem_busywait_i,
  output logic [31:0] if_id_pc_o,
  output logic [31:0] if_id_pc4_o,
  output logic [31:0] if_id_instr_o,
  output logic        if_id_valid_o
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_FETCH   = 2'd1,
    S_HOLD    = 2'd2,
    S_DISCARD = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pending_q, pending_d;
  logic [31:0] hold_q, hold_d;
  logic [31:0] if_id_pc_q, if_id_pc_d;
  logic [31:0] if_id_pc4_q, if_id_pc4_d;
  logic [31:0] if_id_instr_q, if_id_instr_d;
  logic        if_id_valid_q, if_id_valid_d;

  logic [31:0] redirect_tgt;
  logic [31:0] pc_plus4;

  assign redirect_tgt = {redirect_pc_i[31:2], 2'b00};
  assign pc_plus4     = pc_q + 32'd4;

  // PC only moves on completion, so while discarding it still holds the in-flight address.
  assign imem_addr_o  = pc_q;
  assign imem_read_o  = (state_q == S_FETCH) || (state_q == S_DISCARD);

  assign if_id_pc_o    = if_id_pc_q;
  assign if_id_pc4_o   = if_id_pc4_q;
  assign if_id_instr_o = if_id_instr_q;
  assign if_id_valid_o = if_id_valid_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q       <= S_IDLE;
      pc_q          <= RESET_PC;
      pending_q     <= 32'd0;
      hold_q        <= 32'd0;
      if_id_pc_q    <= 32'd0;
      if_id_pc4_q   <= 32'd0;
      if_id_instr_q <= 32'd0;
      if_id_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      pending_q     <= pending_d;
      hold_q        <= hold_d;
      if_id_pc_q    <= if_id_pc_d;
      if_id_pc4_q   <= if_id_pc4_d;
      if_id_instr_q <= if_id_instr_d;
      if_id_valid_q <= if_id_valid_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    pending_d     = pending_q;
    hold_d        = hold_q;
    if_id_pc_d    = if_id_pc_q;
    if_id_pc4_d   = if_id_pc4_q;
    if_id_instr_d = if_id_instr_q;
    if_id_valid_d = if_id_valid_q;

    unique case (state_q)
      S_IDLE: begin
        state_d = S_FETCH;
      end

      S_FETCH: begin
        if (redirect_i) begin
          if_id_valid_d = 1'b0;
          if (!imem_busywait_i) begin
            pc_d = redirect_tgt;
          end else begin
            pending_d = redirect_tgt;
            state_d   = S_DISCARD;
          end
        end else if (!imem_busywait_i) begin
          if (!stall_i) begin
            if_id_pc_d    = pc_q;
            if_id_pc4_d   = pc_plus4;
            if_id_instr_d = imem_readdata_i;
            if_id_valid_d = 1'b1;
            pc_d          = pc_plus4;
          end else begin
            hold_d  = imem_readdata_i;
            state_d = S_HOLD;
          end
        end else if (!stall_i) begin
          if_id_valid_d = 1'b0;
        end
      end

      S_HOLD: begin
        if (redirect_i) begin
          pc_d          = redirect_tgt;
          if_id_valid_d = 1'b0;
          hold_d        = 32'd0;
          state_d       = S_FETCH;
        end else if (!stall_i) begin
          if_id_pc_d    = pc_q;
          if_id_pc4_d   = pc_plus4;
          if_id_instr_d = hold_q;
          if_id_valid_d = 1'b1;
          pc_d          = pc_plus4;
          state_d       = S_FETCH;
        end
      end

      S_DISCARD: begin
        // A redirect landing in the completion cycle is the newest target, so it wins.
        if_id_valid_d = 1'b0;
        if (redirect_i) begin
          pending_d = redirect_tgt;
        end
        if (!imem_busywait_i) begin
          pc_d    = redirect_i ? redirect_tgt : pending_q;
          state_d = S_FETCH;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule
